// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types and constants for the SLC-3 memory/IO bridge.
//   bridge_state_e : bridge FSM states
//   MMIO_ADDR      : single memory-mapped address (switches on read, hex on write)
//   SRAM_AW        : external SRAM address width; ADDR_PAD pads the 16-bit MAR
package slc3_pkg;
  localparam int          DATA_W    = 16;
  localparam int          SRAM_AW   = 20;
  localparam int          ADDR_PAD  = SRAM_AW - DATA_W;
  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RD_HOLD, WR_PULSE, TURN} bridge_state_e;

  function automatic logic is_mmio(input logic [15:0] a);
    return a == MMIO_ADDR;
  endfunction
endpackage

// File: rtl/mem_io_bridge_sync2.sv
// sync2: parameterized-width two-flop synchronizer.
//   Clk, Reset : clock, synchronous active-high reset (clears both stages)
//   d          : asynchronous input
//   q          : synchronized output (two Clk edges of latency)
module sync2 #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: turns the sequencer's Mem_OE/Mem_WE strobes into async SRAM
// control waveforms and decodes one MMIO address (switches / hex display).
//   Clk, Reset          : clock, synchronous active-high reset
//   MAR, MDR_out        : access address and write data from the datapath
//   Mem_OE, Mem_WE      : read / write strobes (write wins when both are high)
//   Switches            : asynchronous board switches (synchronized internally)
//   Data_to_CPU         : read data, valid while Mem_ready in a read
//   Mem_ready           : read data valid / write in progress
//   HEX_data            : hex-display register, written via MMIO_ADDR
//   SRAM_*              : SRAM address, active-low controls, bidirectional data
module mem_io_bridge
  import slc3_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  MAR,
  input  logic [DATA_W-1:0]  MDR_out,
  input  logic               Mem_OE,
  input  logic               Mem_WE,
  input  logic [DATA_W-1:0]  Switches,
  output logic [DATA_W-1:0]  Data_to_CPU,
  output logic               Mem_ready,
  output logic [DATA_W-1:0]  HEX_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  inout  wire  [DATA_W-1:0]  SRAM_DQ
);
  bridge_state_e     state;
  logic [DATA_W-1:0] lat_addr, lat_data, rdata, sw_sync;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Switches),
    .q     (sw_sync)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      rdata    <= '0;
      HEX_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Mem_WE) begin
            lat_addr <= MAR;
            lat_data <= MDR_out;
            // MMIO write commits on the setup edge; the SRAM never sees it
            if (is_mmio(MAR)) HEX_data <= MDR_out;
            state <= WR_PULSE;
          end else if (Mem_OE) begin
            lat_addr <= MAR;
            // capture once; RD_HOLD just presents the held value
            rdata    <= is_mmio(MAR) ? sw_sync : SRAM_DQ;
            state    <= RD_HOLD;
          end
        end
        RD_HOLD:  if (!Mem_OE) state <= IDLE;
        WR_PULSE: if (!Mem_WE) state <= TURN;
        TURN:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Strobes depend on the live Mem_OE/Mem_WE so a read starts in the same
  // cycle the sequencer asserts it; everything is forced inactive in Reset.
  always_comb begin
    SRAM_ADDR   = (state == IDLE) ? {{ADDR_PAD{1'b0}}, MAR} : {{ADDR_PAD{1'b0}}, lat_addr};
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = lat_data;
    Mem_ready   = 1'b0;
    Data_to_CPU = '0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (Mem_WE) begin
            dq_oe  = 1'b1;       // setup cycle: data on the bus, WE_N still high
            dq_out = MDR_out;
          end else if (Mem_OE) begin
            SRAM_OE_N = 1'b0;
          end
        end
        RD_HOLD: begin
          SRAM_OE_N   = 1'b0;
          Mem_ready   = 1'b1;
          Data_to_CPU = rdata;
        end
        WR_PULSE: begin
          dq_oe     = 1'b1;      // held through the WE_N rising edge for hold time
          Mem_ready = 1'b1;
          SRAM_WE_N = ~(Mem_WE & ~is_mmio(lat_addr));
        end
        default: ;               // TURN: bus released, strobes idle
      endcase
    end
  end

  assign SRAM_CE_N = Reset;
  assign SRAM_UB_N = Reset;
  assign SRAM_LB_N = Reset;
  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] MAR, MDR_out, Switches;
  logic        Mem_OE, Mem_WE;
  logic [15:0] Data_to_CPU, HEX_data;
  logic        Mem_ready;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  wire  [15:0] SRAM_DQ;

  always #5 Clk = ~Clk;

  mem_io_bridge dut (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR_out(MDR_out),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Switches(Switches),
    .Data_to_CPU(Data_to_CPU), .Mem_ready(Mem_ready), .HEX_data(HEX_data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_DQ(SRAM_DQ)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] sram [0:4095];
  logic        pre_en;
  logic [11:0] pre_a;
  logic [15:0] pre_d;
  logic        mdl_en, pull_en;
  assign mdl_en  = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = mdl_en  ? sram[SRAM_ADDR[11:0]] : 'z;
  assign SRAM_DQ = pull_en ? 16'h5A5A : 'z;   // known value to spot a non-released bus

  always @(posedge Clk) begin
    if (pre_en) sram[pre_a] <= pre_d;
    else if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR[11:0]] <= SRAM_DQ;
  end

  // ---------------- reference model (transaction level) ----------------
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_hex;

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic [15:0] sw);
    if (a == 16'hFFFF) return sw;
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic void ref_write(input logic [15:0] a, input logic [15:0] d);
    if (a == 16'hFFFF) ref_hex = d;
    else ref_mem[a] = d;
  endfunction

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    Mem_OE = 0; Mem_WE = 0;
    repeat (n) step();
  endtask

  // One complete access, called and returning at posedge+1 with the bridge idle.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                        input int hold, input logic [15:0] exp_rd);
    bit mm;
    mm = (addr == 16'hFFFF);
    MAR = addr; MDR_out = data; Mem_WE = wr; Mem_OE = !wr;
    @(negedge Clk);
    chk("setup_ready", Mem_ready, 0);
    chk("setup_addr", SRAM_ADDR, {4'h0, addr});
    if (wr) begin
      chk("setup_we_n", SRAM_WE_N, 1);
      chk("setup_oe_n", SRAM_OE_N, 1);
      chk("setup_dq", SRAM_DQ, data);
    end else chk("rd_oe_n_c1", SRAM_OE_N, 0);
    for (int c = 1; c < hold; c++) begin
      step();
      @(negedge Clk);
      chk("hold_ready", Mem_ready, 1);
      if (wr) begin
        chk("wr_we_n", SRAM_WE_N, mm);
        chk("wr_dq", SRAM_DQ, data);
      end else begin
        chk("rd_oe_n", SRAM_OE_N, 0);
        chk("rd_data", Data_to_CPU, exp_rd);
      end
    end
    step();
    Mem_OE = 0; Mem_WE = 0;
    @(negedge Clk);
    if (wr) begin
      chk("wr_drop_we_n", SRAM_WE_N, 1);
      step();
      @(negedge Clk);
      chk("turn_ready", Mem_ready, 0);
      chk("turn_strobes", {SRAM_WE_N, SRAM_OE_N}, 2'b11);
    end
    step();
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr, data, sw;
    int          hold;
    logic [15:0] exp_rd, exp_hex;
  } vec_t;

  vec_t vecs[$];

  initial begin
    Reset = 1; MAR = 0; MDR_out = 0; Switches = 0; Mem_OE = 0; Mem_WE = 0;
    pre_en = 0; pre_a = 0; pre_d = 0; pull_en = 0; ref_hex = 0;

    // preload SRAM and reference with the same contents while held in reset
    for (int i = 0; i < 32; i++) begin
      pre_en = 1; pre_a = 12'(i); pre_d = 16'hA000 + 16'(i * 16'h0111);
      ref_mem[16'(i)] = pre_d;
      step();
    end
    pre_en = 1; pre_a = 12'h040; pre_d = 16'h1234; ref_mem[16'h0040] = 16'h1234;
    step();
    pre_en = 0;
    Mem_OE = 1;                      // strobe during reset must not reach the SRAM
    @(negedge Clk);
    chk("rst_ce_n", SRAM_CE_N, 1);
    chk("rst_oe_n", SRAM_OE_N, 1);
    Mem_OE = 0;
    step();
    Reset = 0;
    @(negedge Clk);
    chk("rst_data", Data_to_CPU, 0);
    chk("rst_ready", Mem_ready, 0);
    chk("rst_strobes", {SRAM_OE_N, SRAM_WE_N}, 2'b11);
    chk("rst_hex", HEX_data, 0);
    chk("rst_ce_ub_lb", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);
    step();

    // ---------------- directed vector table ----------------
    vecs.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 2, 16'h1234, 16'h0000});
    vecs.push_back('{1, 16'h0041, 16'hBEEF, 16'h0000, 2, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0041, 16'h0000, 16'h0000, 2, 16'hBEEF, 16'h0000});
    vecs.push_back('{1, 16'hFFFF, 16'h00A5, 16'h0000, 2, 16'h0000, 16'h00A5});
    vecs.push_back('{0, 16'hFFFF, 16'h0000, 16'h0F0F, 2, 16'h0F0F, 16'h00A5});
    vecs.push_back('{1, 16'h0042, 16'hCAFE, 16'h1111, 3, 16'h0000, 16'h00A5});
    vecs.push_back('{0, 16'h0042, 16'h0000, 16'h2222, 3, 16'hCAFE, 16'h00A5});
    foreach (vecs[i]) begin
      Switches = vecs[i].sw;
      idle(3);
      access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].exp_rd);
      if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].data);
      chk("vec_hex", HEX_data, vecs[i].exp_hex);
      if (vecs[i].wr && vecs[i].addr != 16'hFFFF)
        chk("vec_sram_store", sram[vecs[i].addr[11:0]], vecs[i].data);
    end

    // ---------------- priority + turnaround ----------------
    MAR = 16'h0060; MDR_out = 16'h7777; Mem_WE = 1; Mem_OE = 1;
    @(negedge Clk);
    chk("prio_oe_n_c1", SRAM_OE_N, 1);
    chk("prio_we_n_c1", SRAM_WE_N, 1);
    step();
    @(negedge Clk);
    chk("prio_we_n_c2", SRAM_WE_N, 0);
    chk("prio_oe_n_c2", SRAM_OE_N, 1);
    step();
    Mem_WE = 0; Mem_OE = 0;
    @(negedge Clk);
    step();                           // TURN: read requested, must be ignored
    Mem_OE = 1; pull_en = 1;
    @(negedge Clk);
    chk("turn_oe_n", SRAM_OE_N, 1);
    chk("turn_ready2", Mem_ready, 0);
    chk("turn_dq_released", SRAM_DQ, 16'h5A5A);
    step();
    pull_en = 0;
    @(negedge Clk);
    chk("after_turn_oe_n", SRAM_OE_N, 0);
    step();
    @(negedge Clk);
    chk("after_turn_ready", Mem_ready, 1);
    chk("after_turn_data", Data_to_CPU, 16'h7777);
    chk("prio_sram_store", sram[12'h060], 16'h7777);
    ref_write(16'h0060, 16'h7777);
    idle(2);

    // ---------------- address hold during RD_HOLD ----------------
    MAR = 16'h0040; Mem_OE = 1;
    step();
    MAR = 16'h0050;
    @(negedge Clk);
    chk("hold_addr", SRAM_ADDR, 20'h00040);
    chk("hold_data", Data_to_CPU, 16'h1234);
    idle(2);

    // ---------------- randomized against reference ----------------
    for (int t = 0; t < 30; t++) begin
      bit          wr;
      logic [15:0] a, d, sw;
      int          h;
      wr = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      sw = 16'($urandom);
      h  = $urandom_range(2, 4);
      Switches = sw;
      idle(3);
      access(wr, a, d, h, ref_read(a, sw));
      if (wr) ref_write(a, d);
      chk("rnd_hex", HEX_data, ref_hex);
    end

    // ---------------- reset mid-write ----------------
    access(1, 16'hFFFF, 16'h0033, 2, 16'h0000);
    chk("pre_rst_hex", HEX_data, 16'h0033);
    MAR = 16'h0070; MDR_out = 16'h3333; Mem_WE = 1;
    step();
    @(negedge Clk);
    chk("mid_wr_we_n", SRAM_WE_N, 0);
    step();
    Reset = 1;
    @(negedge Clk);
    chk("mid_rst_ce_n", SRAM_CE_N, 1);
    step();
    Reset = 0; Mem_WE = 0; pull_en = 1;
    @(negedge Clk);
    chk("post_rst_we_n", SRAM_WE_N, 1);
    chk("post_rst_dq", SRAM_DQ, 16'h5A5A);
    chk("post_rst_hex", HEX_data, 0);
    chk("post_rst_ready", Mem_ready, 0);
    step();
    pull_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
